// File: rtl/cpu_pkg.sv
// Shared pipeline types for operand forwarding: mux select codes, stage tag layout
// and the tag/source match rule.
package cpu_pkg;

    localparam int REG_AW = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    typedef struct packed {
        logic              v;
        logic              we;
        logic              ld;
        logic [REG_AW-1:0] rd;
    } fwd_tag_t;

    localparam fwd_tag_t FWD_BUBBLE = '0;

    // Register 0 is hardwired zero, so it never matches an in-flight writer.
    function automatic logic tag_hit(input fwd_tag_t t, input logic [REG_AW-1:0] r);
        return t.v & t.we & (t.rd == r) & (r != '0);
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority compare of one decode-stage source against the EX/MEM/WB tags;
// the youngest matching stage wins.
module fwd_match (
    input  cpu_pkg::fwd_tag_t          s1,
    input  cpu_pkg::fwd_tag_t          s2,
    input  cpu_pkg::fwd_tag_t          s3,
    input  logic [cpu_pkg::REG_AW-1:0] rs,
    output logic [1:0]                 sel,
    output logic                       s1_ld_hit
);
    import cpu_pkg::*;

    logic hit1;
    logic hit2;
    logic hit3;

    assign hit1 = tag_hit(s1, rs);
    assign hit2 = tag_hit(s2, rs);
    assign hit3 = tag_hit(s3, rs);

    always_comb begin
        sel = FWD_RF;
        if (hit1) begin
            sel = FWD_EX;
        end else if (hit2) begin
            sel = FWD_MEM;
        end else if (hit3) begin
            sel = FWD_WB;
        end
    end

    assign s1_ld_hit = hit1 & s1.ld;

endmodule

// File: rtl/fwd_select_unit.sv
// Forwarding select generator: tracks EX/MEM/WB destination tags, drives the operand
// mux selects and flags load-use hazards. Optional statistics counters under FWD_STATS_EN.
module fwd_select_unit #(
    parameter int REG_AW = cpu_pkg::REG_AW
`ifdef FWD_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid,
    input  logic              issue_we,
    input  logic              issue_ld,
    input  logic [REG_AW-1:0] issue_rd,
    input  logic              stall,
    input  logic              flush,
    input  logic [REG_AW-1:0] rs_a,
    input  logic [REG_AW-1:0] rs_b,
    output logic [1:0]        sel_a,
    output logic [1:0]        sel_b,
    output logic              load_use
`ifdef FWD_STATS_EN
    ,
    output logic [CNT_W-1:0]  fwd_cnt_ex,
    output logic [CNT_W-1:0]  fwd_cnt_mem,
    output logic [CNT_W-1:0]  fwd_cnt_wb,
    output logic [CNT_W-1:0]  lu_cnt
`endif
);
    import cpu_pkg::*;

    fwd_tag_t s1_reg, s2_reg, s3_reg;
    fwd_tag_t s1_next, s2_next, s3_next;

    // Flush squashes the issuing and EX instructions but lets MEM retire into WB.
    always_comb begin
        s1_next = s1_reg;
        s2_next = s2_reg;
        s3_next = s3_reg;
        if (flush) begin
            s1_next = FWD_BUBBLE;
            s2_next = FWD_BUBBLE;
            s3_next = s2_reg;
        end else if (!stall) begin
            s1_next = '{v: issue_valid, we: issue_we, ld: issue_ld, rd: issue_rd};
            s2_next = s1_reg;
            s3_next = s2_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_reg <= FWD_BUBBLE;
            s2_reg <= FWD_BUBBLE;
            s3_reg <= FWD_BUBBLE;
        end else begin
            s1_reg <= s1_next;
            s2_reg <= s2_next;
            s3_reg <= s3_next;
        end
    end

    logic [REG_AW-1:0] rs_vec     [2];
    logic [1:0]        sel_vec    [2];
    logic              ld_hit_vec [2];

    assign rs_vec[0] = rs_a;
    assign rs_vec[1] = rs_b;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_match
            fwd_match u_match (
                .s1        (s1_reg),
                .s2        (s2_reg),
                .s3        (s3_reg),
                .rs        (rs_vec[gi]),
                .sel       (sel_vec[gi]),
                .s1_ld_hit (ld_hit_vec[gi])
            );
        end
    endgenerate

    assign sel_a    = sel_vec[0];
    assign sel_b    = sel_vec[1];
    assign load_use = ld_hit_vec[0] | ld_hit_vec[1];

`ifdef FWD_STATS_EN
    // Per-cycle increments: 0..2 for the forward counters (one per operand), 0..1 for hazards.
    logic [1:0] cnt_inc [4];

    assign cnt_inc[0] = {1'b0, sel_a == FWD_EX}  + {1'b0, sel_b == FWD_EX};
    assign cnt_inc[1] = {1'b0, sel_a == FWD_MEM} + {1'b0, sel_b == FWD_MEM};
    assign cnt_inc[2] = {1'b0, sel_a == FWD_WB}  + {1'b0, sel_b == FWD_WB};
    assign cnt_inc[3] = {1'b0, load_use};

    generate
        for (gi = 0; gi < 4; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W:0]   sum;

            assign sum = {1'b0, cnt_reg} + (CNT_W+1)'(cnt_inc[gi]);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (!stall) begin
                    cnt_reg <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
                end
            end
        end
    endgenerate

    assign fwd_cnt_ex  = g_cnt[0].cnt_reg;
    assign fwd_cnt_mem = g_cnt[1].cnt_reg;
    assign fwd_cnt_wb  = g_cnt[2].cnt_reg;
    assign lu_cnt      = g_cnt[3].cnt_reg;
`endif

endmodule

// File: tb/tb_fwd_select_unit.sv
// Self-checking bench for fwd_select_unit: reset, directed vector table, async reset,
// randomized run against an age-ordered tag model, and counters when FWD_STATS_EN is set.
module tb_fwd_select_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       issue_valid, issue_we, issue_ld;
    logic [4:0] issue_rd;
    logic       stall, flush;
    logic [4:0] rs_a, rs_b;
    logic [1:0] sel_a, sel_b;
    logic       load_use;
`ifdef FWD_STATS_EN
    logic [15:0] fwd_cnt_ex, fwd_cnt_mem, fwd_cnt_wb, lu_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fwd_select_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_we    (issue_we),
        .issue_ld    (issue_ld),
        .issue_rd    (issue_rd),
        .stall       (stall),
        .flush       (flush),
        .rs_a        (rs_a),
        .rs_b        (rs_b),
        .sel_a       (sel_a),
        .sel_b       (sel_b),
        .load_use    (load_use)
`ifdef FWD_STATS_EN
        ,
        .fwd_cnt_ex  (fwd_cnt_ex),
        .fwd_cnt_mem (fwd_cnt_mem),
        .fwd_cnt_wb  (fwd_cnt_wb),
        .lu_cnt      (lu_cnt)
`endif
    );

    // Reference model: tags ordered by age, index 0 = youngest (EX).
    logic       m_v  [3];
    logic       m_we [3];
    logic       m_ld [3];
    logic [4:0] m_rd [3];

    task automatic model_clear();
        for (int k = 0; k < 3; k++) begin
            m_v[k] = 0; m_we[k] = 0; m_ld[k] = 0; m_rd[k] = 0;
        end
    endtask

    task automatic model_step(input logic v, we, ld, input logic [4:0] rd,
                              input logic st, fl);
        if (fl) begin
            m_v[2] = m_v[1]; m_we[2] = m_we[1]; m_ld[2] = m_ld[1]; m_rd[2] = m_rd[1];
            for (int k = 0; k < 2; k++) begin
                m_v[k] = 0; m_we[k] = 0; m_ld[k] = 0; m_rd[k] = 0;
            end
        end else if (!st) begin
            for (int k = 2; k > 0; k--) begin
                m_v[k] = m_v[k-1]; m_we[k] = m_we[k-1]; m_ld[k] = m_ld[k-1]; m_rd[k] = m_rd[k-1];
            end
            m_v[0] = v; m_we[0] = we; m_ld[0] = ld; m_rd[0] = rd;
        end
    endtask

    // Age of the youngest writer of r (1..3), or 0 when the register file holds it.
    function automatic logic [1:0] model_sel(input logic [4:0] r);
        if (r == 0) return 2'd0;
        for (int k = 0; k < 3; k++)
            if (m_v[k] && m_we[k] && m_rd[k] == r) return 2'(k + 1);
        return 2'd0;
    endfunction

    function automatic logic model_lu(input logic [4:0] ra, rb);
        return m_ld[0] && (model_sel(ra) == 2'd1 || model_sel(rb) == 2'd1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_edge(input logic v, we, ld, input logic [4:0] rd, input logic st, fl);
        issue_valid = v; issue_we = we; issue_ld = ld; issue_rd = rd;
        stall = st; flush = fl;
        @(posedge clk);
        model_step(v, we, ld, rd, st, fl);
        #1;
        issue_valid = 0; issue_we = 0; issue_ld = 0; issue_rd = 0;
        stall = 0; flush = 0;
    endtask

    typedef struct {
        logic v, we, ld;
        logic [4:0] rd;
        logic st, fl;
        logic [4:0] ra, rb;
        logic [1:0] ea, eb;
        logic el;
    } vec_t;

    vec_t tbl [16];

    initial begin
        // Each row: inputs applied at one edge, then sources and expected outputs.
        //            v  we ld rd st fl ra rb  ea     eb     lu
        tbl[0]  = '{1, 1, 0, 5, 0, 0, 5, 0, 2'b01, 2'b00, 0};
        tbl[1]  = '{0, 0, 0, 0, 0, 0, 5, 0, 2'b10, 2'b00, 0};
        tbl[2]  = '{0, 0, 0, 0, 0, 0, 5, 0, 2'b11, 2'b00, 0};
        tbl[3]  = '{0, 0, 0, 0, 0, 0, 5, 0, 2'b00, 2'b00, 0};
        tbl[4]  = '{1, 1, 0, 4, 0, 0, 0, 4, 2'b00, 2'b01, 0};
        tbl[5]  = '{1, 1, 0, 4, 0, 0, 0, 4, 2'b00, 2'b01, 0};
        tbl[6]  = '{1, 1, 0, 4, 0, 0, 4, 4, 2'b01, 2'b01, 0};
        tbl[7]  = '{1, 1, 0, 0, 0, 0, 0, 4, 2'b00, 2'b10, 0};
        tbl[8]  = '{1, 1, 1, 9, 0, 0, 9, 4, 2'b01, 2'b11, 1};
        tbl[9]  = '{1, 1, 0, 12, 1, 0, 9, 4, 2'b01, 2'b11, 1};
        tbl[10] = '{0, 0, 0, 0, 0, 0, 9, 4, 2'b10, 2'b00, 0};
        tbl[11] = '{1, 1, 0, 6, 0, 0, 6, 9, 2'b01, 2'b11, 0};
        tbl[12] = '{1, 1, 0, 2, 0, 0, 6, 2, 2'b10, 2'b01, 0};
        tbl[13] = '{1, 1, 0, 7, 1, 1, 6, 2, 2'b11, 2'b00, 0};
        tbl[14] = '{0, 0, 0, 0, 0, 0, 6, 2, 2'b00, 2'b00, 0};
        tbl[15] = '{1, 0, 0, 3, 0, 0, 3, 0, 2'b00, 2'b00, 0};

        model_clear();
        rst_n = 0;
        issue_valid = 0; issue_we = 0; issue_ld = 0; issue_rd = 0;
        stall = 0; flush = 0;
        rs_a = 3; rs_b = 7;

        // Reset held
        repeat (2) @(posedge clk);
        #1;
        check("rst_sel_a", sel_a, 2'b00);
        check("rst_sel_b", sel_b, 2'b00);
        check("rst_load_use", load_use, 1'b0);
        @(negedge clk);
        rst_n = 1;
        do_edge(0, 0, 0, 0, 0, 0);
        check("post_rst_sel_a", sel_a, 2'b00);
        check("post_rst_sel_b", sel_b, 2'b00);
        check("post_rst_load_use", load_use, 1'b0);

        // Directed vector table
        for (int i = 0; i < 16; i++) begin
            do_edge(tbl[i].v, tbl[i].we, tbl[i].ld, tbl[i].rd, tbl[i].st, tbl[i].fl);
            rs_a = tbl[i].ra; rs_b = tbl[i].rb;
            #1;
            check($sformatf("vec%0d_sel_a", i), sel_a, tbl[i].ea);
            check($sformatf("vec%0d_sel_b", i), sel_b, tbl[i].eb);
            check($sformatf("vec%0d_load_use", i), load_use, tbl[i].el);
            $display("vec %0d: rs_a=%0d rs_b=%0d sel_a=%b sel_b=%b load_use=%b",
                     i, rs_a, rs_b, sel_a, sel_b, load_use);
        end

        // Asynchronous reset mid-cycle clears state without a clock edge
        do_edge(1, 1, 1, 3, 0, 0);
        rs_a = 3; rs_b = 3;
        #1;
        check("pre_async_sel_a", sel_a, 2'b01);
        check("pre_async_load_use", load_use, 1'b1);
        rst_n = 0;
        #1;
        model_clear();
        check("async_rst_sel_a", sel_a, 2'b00);
        check("async_rst_sel_b", sel_b, 2'b00);
        check("async_rst_load_use", load_use, 1'b0);
        @(negedge clk);
        rst_n = 1;

        // Randomized run against the model
        for (int i = 0; i < 400; i++) begin
            logic v, we, ld, st, fl;
            logic [4:0] rd;
            v  = 1'($urandom_range(0, 3) != 0);
            we = 1'($urandom_range(0, 4) != 0);
            ld = 1'($urandom_range(0, 2) == 0);
            rd = 5'($urandom_range(0, 7));
            st = 1'($urandom_range(0, 4) == 0);
            fl = 1'($urandom_range(0, 9) == 0);
            do_edge(v, we, ld, rd, st, fl);
            rs_a = 5'($urandom_range(0, 7));
            rs_b = 5'($urandom_range(0, 7));
            #1;
            check("rand_sel_a", sel_a, model_sel(rs_a));
            check("rand_sel_b", sel_b, model_sel(rs_b));
            check("rand_load_use", load_use, model_lu(rs_a, rs_b));
            $display("rand %0d: st=%b fl=%b rs_a=%0d rs_b=%0d sel_a=%b sel_b=%b load_use=%b",
                     i, st, fl, rs_a, rs_b, sel_a, sel_b, load_use);
        end

`ifdef FWD_STATS_EN
        // Counters: three cycles with both operands from EX count 6
        @(negedge clk);
        rst_n = 0;
        #1;
        rst_n = 1;
        model_clear();
        rs_a = 5; rs_b = 5;
        do_edge(1, 1, 0, 5, 0, 0);
        do_edge(1, 1, 0, 5, 0, 0);
        do_edge(1, 1, 0, 5, 0, 0);
        do_edge(0, 0, 0, 0, 0, 0);
        check("cnt_ex_six", fwd_cnt_ex, 16'd6);
        check("cnt_mem_zero", fwd_cnt_mem, 16'd0);
        check("cnt_lu_zero", lu_cnt, 16'd0);
        $display("stats: ex=%0d mem=%0d wb=%0d lu=%0d", fwd_cnt_ex, fwd_cnt_mem, fwd_cnt_wb, lu_cnt);
        // Saturation
        for (int i = 0; i < 33000; i++) do_edge(1, 1, 0, 5, 0, 0);
        check("cnt_ex_sat", fwd_cnt_ex, 16'hFFFF);
        do_edge(1, 1, 0, 5, 0, 0);
        check("cnt_ex_sat_hold", fwd_cnt_ex, 16'hFFFF);
        $display("stats sat: ex=%0h", fwd_cnt_ex);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
